// File: rtl/dmem_responder_if.sv
// Data-memory bus between the MEM stage (master) and the responder (slave).
// Request: req_valid/req_ready, req_we, req_addr, req_size, req_wdata.
// Response: rsp_valid/rsp_ready, rsp_rdata, rsp_err.
interface dmem_responder_if #(
  parameter int ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: B/H/W loads and stores with funct3 semantics,
// WAIT_CYCLES wait states, error flagging, and a registered debug read port.
// Ports: clk, reset (async, active-high), bus (slave side of
// dmem_responder_if), ext_addr (debug word address), ext_rdata (debug data).
module dmem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  input  logic [ADDR_W-3:0] ext_addr,
  output logic [31:0]       ext_rdata
);
  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam logic [3:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  state_t            stateNext;
  logic [3:0]        cnt;
  logic [3:0]        cntNext;

  logic              weQ;
  logic [ADDR_W-1:0] addrQ;
  logic [2:0]        sizeQ;
  logic [31:0]       wdataQ;
  logic [31:0]       rdataQ;
  logic              errQ;
  logic [31:0]       extQ;

  logic [31:0]       mem [DEPTH];

  logic              doAccess;
  logic              memWr;
  logic              accWe;
  logic [ADDR_W-1:0] accAddr;
  logic [2:0]        accSize;
  logic [31:0]       accWdata;
  logic [ADDR_W-3:0] accIdx;
  logic [31:0]       accWord;
  logic [31:0]       shifted;
  logic              accErr;
  logic [31:0]       loadData;
  logic [3:0]        byteEn;
  logic [31:0]       laneData;
  logic [31:0]       merged;

  // State register plus request capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      weQ    <= 1'b0;
      addrQ  <= '0;
      sizeQ  <= 3'd0;
      wdataQ <= 32'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (state == IDLE && bus.req_valid) begin
        weQ    <= bus.req_we;
        addrQ  <= bus.req_addr;
        sizeQ  <= bus.req_size;
        wdataQ <= bus.req_wdata;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            stateNext = RESP;
          end else begin
            stateNext = WAIT;
            cntNext   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) stateNext = RESP;
        else             cntNext   = cnt - 4'd1;
      end
      RESP: begin
        if (bus.rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.req_ready = (state == IDLE) && !reset;
    bus.rsp_valid = (state == RESP);
    bus.rsp_rdata = rdataQ;
    bus.rsp_err   = errQ;
    ext_rdata     = extQ;
  end

  // With zero wait states the access edge is the acceptance edge,
  // so the live request is used instead of the captured copy.
  always_comb begin
    if (state == IDLE) begin
      accWe    = bus.req_we;
      accAddr  = bus.req_addr;
      accSize  = bus.req_size;
      accWdata = bus.req_wdata;
    end else begin
      accWe    = weQ;
      accAddr  = addrQ;
      accSize  = sizeQ;
      accWdata = wdataQ;
    end
  end

  assign doAccess =
    ((state == IDLE) && bus.req_valid && (WAIT_CYCLES == 0)) ||
    ((state == WAIT) && (cnt == 4'd0));

  assign accIdx  = accAddr[ADDR_W-1:2];
  assign accWord = mem[accIdx];
  assign shifted = accWord >> {accAddr[1:0], 3'b000};

  always_comb begin
    accErr = 1'b1;
    unique case (accSize)
      3'b000:  accErr = 1'b0;
      3'b001:  accErr = accAddr[0];
      3'b010:  accErr = |accAddr[1:0];
      3'b100:  accErr = accWe;
      3'b101:  accErr = accWe | accAddr[0];
      default: accErr = 1'b1;
    endcase
  end

  always_comb begin
    loadData = accWord;
    unique case (accSize)
      3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  loadData = {24'd0, shifted[7:0]};
      3'b101:  loadData = {16'd0, shifted[15:0]};
      default: loadData = accWord;
    endcase
  end

  // Stores replicate the source across lanes and merge by byte enable.
  always_comb begin
    byteEn   = 4'hF;
    laneData = accWdata;
    case (accSize[1:0])
      2'b00: begin
        byteEn   = 4'b0001 << accAddr[1:0];
        laneData = {4{accWdata[7:0]}};
      end
      2'b01: begin
        byteEn   = accAddr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{accWdata[15:0]}};
      end
      default: begin
        byteEn   = 4'hF;
        laneData = accWdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = byteEn[i] ? laneData[8*i +: 8]
                                   : accWord[8*i +: 8];
    end
  end

  assign memWr = doAccess && accWe && !accErr && !reset;

  always_ff @(posedge clk) begin
    if (memWr) mem[accIdx] <= merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdataQ <= 32'd0;
      errQ   <= 1'b0;
    end else if (doAccess) begin
      errQ   <= accErr;
      rdataQ <= (accErr || accWe) ? 32'd0 : loadData;
    end
  end

  // Read-before-write: the array update lands on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) extQ <= 32'd0;
    else       extQ <= mem[ext_addr];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-level memory model with a per-cycle
// compare process, directed literal checks and a randomized phase.
module tb_dmem_responder;
  localparam int AW  = 9;
  localparam int WC  = 1;
  localparam int WC3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst1;
  logic          rst3;
  logic [AW-3:0] ext1;
  logic [AW-3:0] ext3;
  logic [31:0]   extData1;
  logic [31:0]   extData3;

  dmem_responder_if #(.ADDR_W(AW)) bus1 ();
  dmem_responder_if #(.ADDR_W(AW)) bus3 ();

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut1 (
    .clk(clk), .reset(rst1), .bus(bus1),
    .ext_addr(ext1), .ext_rdata(extData1)
  );

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC3)) dut3 (
    .clk(clk), .reset(rst3), .bus(bus3),
    .ext_addr(ext3), .ext_rdata(extData3)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] mb [512];
  logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  bit          chkOn = 0;
  int          cyc = 0;
  bit          pend = 0;
  bit          pDone = 0;
  bit          pWe;
  logic [8:0]  pAddr;
  logic [2:0]  pSize;
  logic [31:0] pWdata;
  int          pDue;
  bit          eErr;
  logic [31:0] eRd;
  logic [31:0] extExp;
  bit          extOk = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-addressed reference: n-byte access, aligned, little-endian.
  task automatic model(input bit we, input logic [8:0] a,
                       input logic [2:0] sz, input logic [31:0] wd,
                       output bit err, output logic [31:0] rd);
    int n;
    int base;
    n = 1 << sz[1:0];
    base = int'(a);
    err = (sz == 3'd3) || (sz == 3'd6) || (sz == 3'd7) ||
          (we && sz[2]) || ((base % n) != 0);
    rd = 32'd0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (we) mb[base+i] = wd[8*i +: 8];
        else    rd[8*i +: 8] = mb[base+i];
      end
      if (!we && !sz[2] && n < 4 && rd[8*n-1])
        rd = rd | (32'hFFFF_FFFF << (8*n));
    end
  endtask

  function automatic logic [31:0] mword(input logic [AW-3:0] w);
    int b;
    b = int'(w) * 4;
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  // Per-cycle comparison of dut1 against the model.
  always @(negedge clk) begin
    if (chkOn) begin
      cyc++;
      if (pend && !pDone && cyc >= pDue) begin
        model(pWe, pAddr, pSize, pWdata, eErr, eRd);
        pDone = 1;
      end
      chk("rsp_valid", 32'(bus1.rsp_valid), 32'(pend && pDone));
      chk("req_ready", 32'(bus1.req_ready), 32'(!pend));
      if (pend && pDone) begin
        chk("rsp_rdata", bus1.rsp_rdata, eRd);
        chk("rsp_err", 32'(bus1.rsp_err), 32'(eErr));
      end
      if (extOk) chk("ext_rdata", extData1, extExp);
      extExp = mword(ext1);
      extOk  = !$isunknown(extExp);
      if (pend && pDone && bus1.rsp_valid && bus1.rsp_ready) begin
        pend  = 0;
        pDone = 0;
      end else if (!pend && bus1.req_valid && bus1.req_ready) begin
        pend   = 1;
        pWe    = bus1.req_we;
        pAddr  = bus1.req_addr;
        pSize  = bus1.req_size;
        pWdata = bus1.req_wdata;
        pDue   = cyc + 1 + WC;
      end
    end
  end

  task automatic doReq(input bit we, input logic [8:0] a,
                       input logic [2:0] sz, input logic [31:0] wd,
                       output logic [31:0] rd, output bit err,
                       output int lat);
    int n;
    rd  = 32'hx;
    err = 1'b0;
    lat = -1;
    @(posedge clk); #1;
    bus1.req_valid = 1'b1;
    bus1.req_we    = we;
    bus1.req_addr  = a;
    bus1.req_size  = sz;
    bus1.req_wdata = wd;
    bus1.rsp_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus1.req_ready && n < 50);
    if (!bus1.req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready low 50 cycles, want 1");
      bus1.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus1.rsp_valid && n < 50);
    if (!bus1.rsp_valid) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: rsp_valid low 50 cycles, want 1");
      return;
    end
    rd  = bus1.rsp_rdata;
    err = bus1.rsp_err;
    lat = n;
    @(posedge clk); #1;
  endtask

  task automatic dir(input string nm, input bit we, input logic [8:0] a,
                     input logic [2:0] sz, input logic [31:0] wd,
                     input logic [31:0] expRd, input bit expErr);
    logic [31:0] rd;
    bit          err;
    int          lat;
    doReq(we, a, sz, wd, rd, err, lat);
    chk({nm, "_rdata"}, rd, expRd);
    chk({nm, "_err"}, 32'(err), 32'(expErr));
    chk({nm, "_lat"}, 32'(lat), 32'(WC + 1));
  endtask

  task automatic doReq3(input bit we, input logic [8:0] a,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    int n;
    rd  = 32'hx;
    lat = -1;
    @(posedge clk); #1;
    bus3.req_valid = 1'b1;
    bus3.req_we    = we;
    bus3.req_addr  = a;
    bus3.req_size  = sz;
    bus3.req_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus3.req_ready && n < 50);
    if (!bus3.req_ready) begin
      tests++; fails++;
      $display("FAIL accept3_timeout: req_ready low 50 cycles, want 1");
      bus3.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus3.rsp_valid && n < 50);
    if (!bus3.rsp_valid) begin
      tests++; fails++;
      $display("FAIL rsp3_timeout: rsp_valid low 50 cycles, want 1");
      return;
    end
    rd  = bus3.rsp_rdata;
    lat = n;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          err;
    int          lat;
    int          n;
    logic [8:0]  a;
    logic [2:0]  sz;

    rst1 = 1'b1;
    rst3 = 1'b1;
    ext1 = '0;
    ext3 = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
    bus1.req_size = 3'd0; bus1.req_wdata = 32'd0; bus1.rsp_ready = 1'b1;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0;
    bus3.req_size = 3'd0; bus3.req_wdata = 32'd0; bus3.rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus1.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus1.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus1.rsp_err), 32'd0);
    chk("rst_ext_rdata", extData1, 32'd0);
    chk("rst3_req_ready", 32'(bus3.req_ready), 32'd0);

    @(posedge clk); #1;
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(bus1.req_ready), 32'd1);
    chkOn = 1;

    for (int w = 0; w < 128; w++)
      doReq(1'b1, 9'(w * 4), 3'd2, $urandom, rd, err, lat);

    dir("sw_010", 1, 9'h010, 3'b010, 32'hDEADBEEF, 32'h0, 0);
    dir("lw_010", 0, 9'h010, 3'b010, 32'h0, 32'hDEADBEEF, 0);
    dir("lb_013", 0, 9'h013, 3'b000, 32'h0, 32'hFFFFFFDE, 0);
    dir("lbu_013", 0, 9'h013, 3'b100, 32'h0, 32'h000000DE, 0);
    dir("lh_010", 0, 9'h010, 3'b001, 32'h0, 32'hFFFFBEEF, 0);
    dir("lhu_012", 0, 9'h012, 3'b101, 32'h0, 32'h0000DEAD, 0);
    dir("sb_011", 1, 9'h011, 3'b000, 32'h000000AA, 32'h0, 0);
    dir("lw_sb", 0, 9'h010, 3'b010, 32'h0, 32'hDEADAAEF, 0);
    dir("sh_012", 1, 9'h012, 3'b001, 32'h00001234, 32'h0, 0);
    dir("lw_sh", 0, 9'h010, 3'b010, 32'h0, 32'h1234AAEF, 0);
    dir("lw_mis", 0, 9'h012, 3'b010, 32'h0, 32'h0, 1);
    dir("sh_mis", 1, 9'h011, 3'b001, 32'hFFFF, 32'h0, 1);
    dir("shu_ill", 1, 9'h010, 3'b101, 32'hFFFF, 32'h0, 1);
    dir("lw_keep", 0, 9'h010, 3'b010, 32'h0, 32'h1234AAEF, 0);
    dir("sz011", 0, 9'h010, 3'b011, 32'h0, 32'h0, 1);

    // Back-pressure with a second request waiting.
    @(posedge clk); #1;
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0;
    bus1.req_addr = 9'h010; bus1.req_size = 3'b010;
    bus1.rsp_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus1.req_ready && n < 50);
    @(posedge clk); #1;
    bus1.req_addr = 9'h013; bus1.req_size = 3'b100;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus1.rsp_valid && n < 50);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus1.rsp_valid), 32'd1);
      chk("bp_rdata", bus1.rsp_rdata, 32'h1234AAEF);
      chk("bp_ready", 32'(bus1.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_second_ready", 32'(bus1.req_ready), 32'd1);
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus1.rsp_valid && n < 50);
    chk("bp_second_rdata", bus1.rsp_rdata, 32'h00000012);
    chk("bp_second_lat", 32'(n), 32'(WC + 1));
    @(posedge clk); #1;

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                                       : legal[$urandom_range(0, 4)];
      a = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 63))
                                      : 9'($urandom);
      if ($urandom_range(0, 3) != 0)
        a = a & ~9'((1 << sz[1:0]) - 1);
      bus1.req_valid = ($urandom_range(0, 3) != 0);
      bus1.req_we    = 1'($urandom_range(0, 1));
      bus1.req_addr  = a;
      bus1.req_size  = sz;
      bus1.req_wdata = $urandom;
      bus1.rsp_ready = ($urandom_range(0, 3) != 0);
      ext1           = 7'($urandom);
    end
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    bus1.rsp_ready = 1'b1;
    repeat (10) @(posedge clk);

    // Deep wait states and reset during an outstanding store.
    ext3 = 7'h08;
    doReq3(1'b1, 9'h020, 3'b010, 32'h11111111, rd, lat);
    chk("w3_store_lat", 32'(lat), 32'(WC3 + 1));
    doReq3(1'b0, 9'h020, 3'b010, 32'h0, rd, lat);
    chk("w3_load", rd, 32'h11111111);
    chk("w3_load_lat", 32'(lat), 32'(WC3 + 1));
    @(posedge clk); #1;
    bus3.req_valid = 1'b1; bus3.req_we = 1'b1;
    bus3.req_addr = 9'h020; bus3.req_size = 3'b010;
    bus3.req_wdata = 32'h00000055;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus3.req_ready && n < 50);
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b1;
    #1;
    chk("mid_rst_req_ready", 32'(bus3.req_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus3.rsp_valid), 32'd0);
    chk("mid_rst_rsp_rdata", bus3.rsp_rdata, 32'd0);
    chk("mid_rst_rsp_err", 32'(bus3.rsp_err), 32'd0);
    chk("mid_rst_ext_rdata", extData3, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_ext", extData3, 32'h11111111);
    chk("post_rst_ready", 32'(bus3.req_ready), 32'd1);
    chk("post_rst_valid", 32'(bus3.rsp_valid), 32'd0);
    doReq3(1'b0, 9'h020, 3'b010, 32'h0, rd, lat);
    chk("post_rst_load", rd, 32'h11111111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
